// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CLA_WIDTH = 16;
  localparam int unsigned CLA_GROUP = 4;

  function automatic int unsigned cla_ngroups(input int unsigned width, input int unsigned group);
    return width / group;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [CLA_WIDTH-1:0] sum;
    logic [CLA_WIDTH-1:0] xr;
    logic [CLA_WIDTH-1:0] yr;
    logic                 carry;
    logic                 c_msb_m1;
  } cla_stage_t;

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead group, purely combinational.
module cla_group import cla_pkg::*; #(
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] x,
  input  logic [GROUP-1:0] y,
  input  logic             c,
  output logic [GROUP-1:0] z,
  output logic [GROUP-1:0] p,
  output logic [GROUP-1:0] g,
  output logic             grp_p,
  output logic             grp_g,
  output logic             cout
);

  logic [GROUP-1:0] c_int;
  logic             term;
  logic             carry;

  // Every internal carry is a flat sum of products of g/p and c, not a ripple chain.
  always_comb begin
    p        = x ^ y;
    g        = x & y;
    c_int    = '0;
    c_int[0] = c;
    term     = 1'b0;
    carry    = 1'b0;
    for (int unsigned i = 1; i < GROUP; i++) begin
      term = c;
      for (int unsigned k = 0; k < i; k++) term = term & p[k];
      carry = term;
      for (int unsigned j = 0; j < i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k < i; k++) term = term & p[k];
        carry = carry | term;
      end
      c_int[i] = carry;
    end
    z     = p ^ c_int;
    grp_p = &p;
    grp_g = 1'b0;
    for (int unsigned j = 0; j < GROUP; j++) begin
      term = g[j];
      for (int unsigned k = j + 1; k < GROUP; k++) term = term & p[k];
      grp_g = grp_g | term;
    end
    cout = grp_g | (grp_p & c);
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one lookahead group per stage.
module cla_pipe_adder import cla_pkg::*; #(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NGROUPS = cla_ngroups(WIDTH, GROUP);

  if (GROUP == 0 || (WIDTH % GROUP) != 0) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  // Same layout as cla_stage_t, sized by the module parameters.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic             carry;
    logic             c_msb_m1;
  } stage_t;

  stage_t           src  [NGROUPS];
  stage_t           st_d [NGROUPS];
  stage_t           st_q [NGROUPS];
  logic [GROUP-1:0] grp_z  [NGROUPS];
  logic [GROUP-1:0] grp_pb [NGROUPS];
  logic [GROUP-1:0] grp_gb [NGROUPS];
  logic             grp_pp [NGROUPS];
  logic             grp_gg [NGROUPS];
  logic             grp_co [NGROUPS];
  logic             advance;
  logic             accept;
  logic             unused_bits;

  // Handshake and per-stage inputs: stage 0 sees the offered operands, the rest their predecessor.
  always_comb begin
    advance           = !out_valid || out_ready;
    in_ready          = advance && !rst;
    accept            = in_valid && in_ready;
    src[0]            = '0;
    src[0].valid      = accept;
    src[0].xr         = x;
    src[0].yr         = sub ? ~y : y;
    src[0].carry      = sub ? 1'b1 : cin;
    for (int unsigned s = 1; s < NGROUPS; s++) src[s] = st_q[s-1];
  end

  for (genvar s = 0; s < NGROUPS; s++) begin : g_stage
    cla_group #(.GROUP(GROUP)) u_group (
      .x     (src[s].xr[s*GROUP +: GROUP]),
      .y     (src[s].yr[s*GROUP +: GROUP]),
      .c     (src[s].carry),
      .z     (grp_z[s]),
      .p     (grp_pb[s]),
      .g     (grp_gb[s]),
      .grp_p (grp_pp[s]),
      .grp_g (grp_gg[s]),
      .cout  (grp_co[s])
    );
  end

  // Each stage inserts its finished group and forwards carry; c[msb] recovered as z^p at the top bit.
  always_comb begin
    st_d = src;
    for (int unsigned s = 0; s < NGROUPS; s++) begin
      st_d[s].sum[s*GROUP +: GROUP] = grp_z[s];
      st_d[s].carry                 = grp_co[s];
      st_d[s].c_msb_m1              = grp_z[s][GROUP-1] ^ grp_pb[s][GROUP-1];
    end
  end

  // Whole pipeline shifts together on advance and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= '{default: '0};
    end else if (advance) begin
      st_q <= st_d;
    end
  end

  // The last stage register is the output register.
  always_comb begin
    out_valid = st_q[NGROUPS-1].valid;
    z         = st_q[NGROUPS-1].sum;
    cout      = st_q[NGROUPS-1].carry;
    ovf       = st_q[NGROUPS-1].carry ^ st_q[NGROUPS-1].c_msb_m1;
  end

  always_comb begin
    unused_bits = ^{st_q[NGROUPS-1].xr, st_q[NGROUPS-1].yr};
    for (int unsigned s = 0; s < NGROUPS; s++) begin
      unused_bits = unused_bits ^ (^{grp_gb[s], grp_pp[s], grp_gg[s]});
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;

  localparam int unsigned NG = 4;

  typedef struct {
    logic [15:0] z;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
    logic [15:0] ez;
    logic        ec;
    logic        eo;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit sw_done [2];

  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] x, y, z;
  exp_t        q[$];

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned w, input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic sb);
    logic [31:0] m, xa, yb, s;
    exp_t e;
    m      = (32'd1 << w) - 32'd1;
    xa     = {16'd0, a} & m;
    yb     = {16'd0, (sb ? ~b : b)} & m;
    s      = xa + yb + {31'd0, (sb ? 1'b1 : ci)};
    e.z    = 16'(s & m);
    e.cout = s[w];
    e.ovf  = (xa[w-1] == yb[w-1]) && (s[w-1] != xa[w-1]);
    e.acc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  task automatic issue(input logic [15:0] ix, input logic [15:0] iy, input logic icin, input logic isub,
                       input bit push, input exp_t e, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    @(negedge clk);
    x = ix; y = iy; cin = icin; sub = isub; in_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      #4;
      if (in_ready) begin
        ok = 1'b1;
        e.acc = cyc + 1;
        if (push) q.push_back(e);
        break;
      end
      waited++;
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic issue_rand(input bit push, input bit lat, output int waited);
    logic [15:0] rx, ry;
    logic        rc, rs;
    exp_t        e;
    rx = 16'($urandom); ry = 16'($urandom);
    rc = 1'($urandom);  rs = 1'($urandom);
    e     = model(16, rx, ry, rc, rs);
    e.lat = lat;
    issue(rx, ry, rc, rs, push, e, waited);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge clk);
    chk("drain_pending", 64'(q.size()), 64'd0);
  endtask

  // Scoreboard monitor for the 16-bit instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out z=%h cout=%b ovf=%b but no result was pending", z, cout, ovf);
        end else begin
          e = q.pop_front();
          chk("z", 64'(z), 64'(e.z));
          chk("cout", 64'(cout), 64'(e.cout));
          chk("ovf", 64'(ovf), 64'(e.ovf));
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(NG - 1));
        end
      end
    end
  end

  // Random sweeps on the smaller configurations, each with its own driver and monitor.
  for (genvar k = 0; k < 2; k++) begin : g_sw
    localparam int unsigned SW = (k == 0) ? 8 : 12;
    localparam int unsigned SG = (k == 0) ? 2 : 3;
    logic          s_rst, s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout, s_ovf;
    logic [SW-1:0] s_x, s_y, s_z;
    exp_t          sq[$];

    cla_pipe_adder #(.WIDTH(SW), .GROUP(SG)) u_sw (
      .clk       (clk),
      .rst       (s_rst),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .x         (s_x),
      .y         (s_y),
      .cin       (s_cin),
      .sub       (s_sub),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .z         (s_z),
      .cout      (s_cout),
      .ovf       (s_ovf)
    );

    initial begin
      int   acc_n;
      exp_t e;
      s_rst = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b1;
      s_x = '0; s_y = '0; s_cin = 1'b0; s_sub = 1'b0;
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
      acc_n = 0;
      for (int n = 0; n < 1000 && acc_n < 40; n++) begin
        @(negedge clk);
        s_out_ready = ($urandom_range(0, 3) != 0);
        s_in_valid  = 1'($urandom);
        s_x = SW'($urandom); s_y = SW'($urandom);
        s_cin = 1'($urandom); s_sub = 1'($urandom);
        #4;
        if (s_in_valid && s_in_ready) begin
          e = model(SW, 16'(s_x), 16'(s_y), s_cin, s_sub);
          sq.push_back(e);
          acc_n++;
        end
      end
      @(negedge clk);
      s_in_valid = 1'b0; s_out_ready = 1'b1;
      for (int n = 0; n < 100 && sq.size() != 0; n++) @(negedge clk);
      chk("sw_drain_pending", 64'(sq.size()), 64'd0);
      sw_done[k] = 1'b1;
    end

    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        #4;
        if (s_out_valid === 1'b1 && s_out_ready === 1'b1) begin
          if (sq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sw_unexpected_out width=%0d z=%h but no result was pending", SW, s_z);
          end else begin
            e = sq.pop_front();
            chk("sw_z", 64'(s_z), 64'(e.z));
            chk("sw_cout", 64'(s_cout), 64'(e.cout));
            chk("sw_ovf", 64'(s_ovf), 64'(e.ovf));
          end
        end
      end
    end
  end

  initial begin
    vec_t        vecs [10];
    exp_t        e;
    int          waited;
    logic [15:0] hz;
    logic        hc, ho;

    vecs = '{
      '{16'h000B, 16'h0002, 1'b0, 1'b0, 16'h000D, 1'b0, 1'b0},
      '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
      '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0},
      '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
      '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0},
      '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
      '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0},
      '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0},
      '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0}
    };

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_z", 64'(z), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, back to back.
    foreach (vecs[i]) begin
      e = '{z: vecs[i].ez, cout: vecs[i].ec, ovf: vecs[i].eo, acc: 0, lat: 1'b1};
      issue(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub, 1'b1, e, waited);
    end
    wait_drain();

    // Streaming: no stall expected while out_ready stays high.
    for (int i = 0; i < 8; i++) begin
      issue_rand(1'b1, 1'b1, waited);
      chk("stream_no_stall", 64'(waited), 64'd0);
    end
    wait_drain();

    // Backpressure: fill the pipe, then stall the consumer for 5 cycles.
    for (int i = 0; i < 4; i++) issue_rand(1'b1, 1'b0, waited);
    out_ready = 1'b0;
    hz = z; hc = cout; ho = ovf;
    fork
      issue_rand(1'b1, 1'b0, waited);
      begin
        repeat (5) begin
          @(negedge clk);
          #4;
          chk("bp_out_valid", 64'(out_valid), 64'd1);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          chk("bp_z_stable", 64'(z), 64'(hz));
          chk("bp_cout_stable", 64'(cout), 64'(hc));
          chk("bp_ovf_stable", 64'(ovf), 64'(ho));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with three operations in flight: none of them may ever emerge.
    for (int i = 0; i < 3; i++) issue_rand(1'b0, 1'b0, waited);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; x = 16'h1111; y = 16'h2222; cin = 1'b0; sub = 1'b0;
    #4 chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_z", 64'(z), 64'd0);
    rst = 1'b0;
    #1 chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
    e = '{z: 16'h1000, cout: 1'b0, ovf: 1'b0, acc: 0, lat: 1'b1};
    issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1, e, waited);
    wait_drain();
    repeat (8) @(negedge clk);

    for (int n = 0; n < 3000 && !(sw_done[0] && sw_done[1]); n++) @(negedge clk);
    chk("sweeps_done", 64'({sw_done[0], sw_done[1]}), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
